// File: rtl/data_demux_fsm.sv
// Receive-side demux for the 3-stream TDM link: tracks the transmitter's dwell schedule and
// steers each valid word into one of three held output registers with a 1-cycle strobe.

module data_demux_lane #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_i,
  input  logic [DW-1:0] data_i,
  output logic [DW-1:0] data_o,
  output logic          valid_o
);

  logic [DW-1:0] data_q;
  logic          valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= wr_i;
      if (wr_i) data_q <= data_i;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

module data_demux_fsm #(
  parameter int DW = 32,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2:0]    mode_i,
  input  logic [CW-1:0] switch_clk_cycles_i,
  input  logic          resync_i,
  input  logic [DW-1:0] in_data_i,
  input  logic          in_valid_i,
  output logic [DW-1:0] ds1_data_o,
  output logic [DW-1:0] ds2_data_o,
  output logic [DW-1:0] ds3_data_o,
  output logic          ds1_valid_o,
  output logic          ds2_valid_o,
  output logic          ds3_valid_o,
  output logic [1:0]    slot_o,
  output logic          slot_switch_o
);

  localparam int NUM_LANES = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MODE1 = 2'd1,
    S_MODE2 = 2'd2,
    S_MODE3 = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   dwell_q, dwell_d;
  logic [1:0]      slot_q, slot_d;
  logic            slot_switch_q, slot_switch_d;

  logic [CW-1:0]   dwell_last;
  logic [1:0]      slot_adv;
  logic            restart;

  logic [NUM_LANES-1:0]         lane_wr;
  logic [NUM_LANES-1:0][DW-1:0] lane_data;
  logic [NUM_LANES-1:0]         lane_vld;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      dwell_q       <= '0;
      slot_q        <= 2'd0;
      slot_switch_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      dwell_q       <= dwell_d;
      slot_q        <= slot_d;
      slot_switch_q <= slot_switch_d;
    end
  end

  // Next-state: unknown mode codes leave the FSM where it is
  always_comb begin
    state_d = state_q;
    case (mode_i)
      3'd1:    state_d = S_MODE1;
      3'd2:    state_d = S_MODE2;
      3'd3:    state_d = S_MODE3;
      default: state_d = state_q;
    endcase
  end

  // A zero dwell setting behaves as one cycle, so the last count is 0 either way
  assign dwell_last = (switch_clk_cycles_i == '0) ? '0 : switch_clk_cycles_i - 1'b1;
  assign restart    = resync_i || (state_d != state_q);

  always_comb begin
    slot_adv = 2'd0;
    case (state_q)
      S_MODE3: slot_adv = (slot_q == 2'd2) ? 2'd0 : slot_q + 2'd1;
      S_MODE2: slot_adv = (slot_q == 2'd1) ? 2'd0 : 2'd1;
      default: slot_adv = 2'd0;
    endcase
  end

  // Schedule and routing outputs
  always_comb begin
    dwell_d       = '0;
    slot_d        = 2'd0;
    slot_switch_d = 1'b0;
    lane_wr       = '0;

    if (restart) begin
      dwell_d = '0;
      slot_d  = 2'd0;
    end else if (state_q == S_MODE2 || state_q == S_MODE3) begin
      // >= also catches a dwell setting lowered below the running count
      if (dwell_q >= dwell_last) begin
        dwell_d       = '0;
        slot_d        = slot_adv;
        slot_switch_d = 1'b1;
      end else begin
        dwell_d = dwell_q + 1'b1;
        slot_d  = slot_q;
      end
    end

    // Routing uses the pre-update slot so an advancing cycle still lands in the old stream
    if (in_valid_i && state_q != S_IDLE) begin
      for (int i = 0; i < NUM_LANES; i++)
        lane_wr[i] = (slot_q == 2'(i));
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    data_demux_lane #(.DW(DW)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_i    (lane_wr[g]),
      .data_i  (in_data_i),
      .data_o  (lane_data[g]),
      .valid_o (lane_vld[g])
    );
  end

  assign ds1_data_o    = lane_data[0];
  assign ds2_data_o    = lane_data[1];
  assign ds3_data_o    = lane_data[2];
  assign ds1_valid_o   = lane_vld[0];
  assign ds2_valid_o   = lane_vld[1];
  assign ds3_valid_o   = lane_vld[2];
  assign slot_o        = slot_q;
  assign slot_switch_o = slot_switch_q;

endmodule
